regfile_sb: RTL and testbench
=============================

# regfile_sb

Integer register file with an in-flight-writer scoreboard. It is the consumer of the writeback stage's write port: it takes `wr_en`, `regDest` and `data_out` from WB and commits them. It serves two combinational read ports to decode, with same-cycle write-to-read bypass. It also tracks the number of pending writers per register and raises a stall to decode on read-after-write hazards.

## Interface
- N, 32, data width
- NREG, 32, architectural registers; x0 hardwired to zero
- CNT_W, 2, per-register pending-writer counter width (max 3 in flight)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  WB write enable
- regDest  in  6  WB destination; [4:0] index, [5] must be 0
- wr_data  in  N  WB write data
- rs1_addr, rs2_addr  in  5  read indices from decode
- rs1_used, rs2_used  in  1  source actually consumed by the instruction in decode
- rs1_data, rs2_data  out  N  read data, combinational
- iss_valid  in  1  decode wants to issue an instruction that writes a register
- iss_rd  in  5  destination of the issuing instruction
- kill_valid  in  1  an issued, not-yet-retired writer is squashed
- kill_rd  in  5  destination of the squashed writer
- stall  out  1  decode must hold; issue is suppressed
- sb_err  out  1  sticky: counter underflow or illegal regDest[5]

## Operation
- Write: on a rising edge with `wr_en=1`, `regDest[5]=0` and `regDest[4:0]!=0`, `regs[regDest[4:0]] <= wr_data`.
  - A write with `regDest[5]=1` is dropped and sets `sb_err`.
  - Writes to x0 are dropped silently.
- Read: `rsX_data` is 0 when `rsX_addr=0`.
  - Otherwise it is `wr_data` when a legal write to the same index is active this cycle (write-first bypass).
  - Otherwise it is `regs[rsX_addr]`.
- Scoreboard: one CNT_W counter per register (x0's counter is held at 0). Each cycle, per index, the counter changes by `inc - dec_wb - dec_kill`:
  - `inc`: `iss_valid & ~stall & iss_rd==i & i!=0`
  - `dec_wb`: a legal write to i
  - `dec_kill`: `kill_valid & kill_rd==i`
  - The net change is applied in a single update. Simultaneous inc and dec on one index leaves the count unchanged.
  - If a decrement would take a counter below 0, the counter stays at 0 and `sb_err` sets.
- Hazard per source X, with `ready_X` true when `cnt[rsX]==0`, or when `cnt[rsX]==1` and a WB write to rsX is active this cycle (the data is bypassed):
  - `hazX = rsX_used & rsX_addr!=0 & ~ready_X`
- Overflow guard: `ovf = iss_valid & iss_rd!=0 & cnt[iss_rd]==3 & ~(dec_wb|dec_kill on iss_rd)`.
- `stall = haz1 | haz2 | ovf`. `stall` depends only on current inputs and state; it has no registered delay.
- `sb_err` clears only on `rst`.

## Timing
- Reset (sync, `rst=1` at an edge): all regs = 0, all counters = 0, `sb_err=0`.
  - `rst` mid-operation discards pending counts. The writes of the reset cycle are not committed.
- Write latency: committed at the edge. Reads in the same cycle see the value via bypass; reads in the next cycle see it from storage.
- Issue at edge k: `cnt` increments at k. A dependent reader stalls from cycle k+1 until the cycle WB writes that register; it unstalls combinationally in that cycle.
- `stall` is combinational from `rs*`, `iss_*`, `wr_en`, `regDest`, `kill_*` and the counters. No path exists from `stall` back to its own inputs.

## Structure
- Package `rv_pkg`: `NREG`, `REG_IDX_W=5`, `DEST_W=6`, `CNT_W`, and a `reg_idx_t` typedef shared with decode and WB.
- Sub-module `sb_counter`: one saturating up/down counter with inputs inc, dec_a, dec_b and outputs cnt and underflow. It is instantiated per register via generate. The storage array and read/bypass muxes stay in the top module.

## Test plan
- Reset, then read x5 and x0 -> both 0; `stall=0`; `sb_err=0`.
- Write x7=0xDEADBEEF while reading rs1=x7 in the same cycle -> `rs1_data=0xDEADBEEF`. Next cycle, with no write active -> still 0xDEADBEEF.
- Issue rd=x3. Next cycle, rs2=x3 with `rs2_used=1` -> `stall=1`. In the WB-write-x3 cycle -> `stall=0` and `rs2_data=` the WB data. After that, cnt[3]=0.
- Issue x4 three times, then a fourth issue of x4 -> `stall=1` with count held at 3. The fourth issue in a cycle where a kill of x4 is active -> accepted, count stays 3.
- Same-cycle issue x9 and WB write x9 (cnt 1) -> cnt stays 1, and a reader of x9 next cycle stalls. Kill x9 -> cnt 0, `stall=0`.
- WB write with `regDest=6'b100010` -> x2 unchanged, `sb_err=1` and sticky until `rst`. Kill of x6 at cnt 0 -> cnt stays 0, `sb_err=1`.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package rv_pkg;

  localparam int N         = 32;  // data width
  localparam int NREG      = 32;  // architectural registers, x0 hardwired to zero
  localparam int REG_IDX_W = 5;   // register index width
  localparam int DEST_W    = 6;   // WB destination width; top bit must be 0
  localparam int CNT_W     = 2;   // pending-writer counter width

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of WB write port, decode read ports, issue/kill and hazard signals.
//
// Handshake: there is no valid/ready pair here. wr_en, iss_valid and
// kill_valid are single-cycle qualifiers sampled on the rising edge. stall
// is the only back-pressure: when stall=1 the regfile ignores iss_valid in
// that cycle, and decode is expected to hold the same instruction.
interface regfile_sb_if;
  import rv_pkg::*;

  logic                     wr_en;
  logic [DEST_W-1:0]        regDest;
  logic [N-1:0]             wr_data;
  reg_idx_t                 rs1_addr;
  reg_idx_t                 rs2_addr;
  logic                     rs1_used;
  logic                     rs2_used;
  logic [N-1:0]             rs1_data;
  logic [N-1:0]             rs2_data;
  logic                     iss_valid;
  reg_idx_t                 iss_rd;
  logic                     kill_valid;
  reg_idx_t                 kill_rd;
  logic                     stall;
  logic                     sb_err;
  // Debug view of every pending-writer counter.
  logic [NREG-1:0][CNT_W-1:0] dbg_cnt;

  modport slave (
    input  wr_en, regDest, wr_data,
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  iss_valid, iss_rd, kill_valid, kill_rd,
    output rs1_data, rs2_data, stall, sb_err, dbg_cnt
  );

  modport master (
    output wr_en, regDest, wr_data,
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output iss_valid, iss_rd, kill_valid, kill_rd,
    input  rs1_data, rs2_data, stall, sb_err, dbg_cnt
  );

endinterface

// File: rtl/sb_counter.sv
// One pending-writer counter: net change inc - dec_a - dec_b applied in a
// single update, clamped at 0 (flagging underflow) and at the maximum.
module sb_counter
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_up;
  logic [CNT_W:0]   w_dn;
  logic [CNT_W:0]   w_diff;
  logic [CNT_W-1:0] w_next;

  // Compute the next count from the combined increment/decrement.
  always_comb begin
    w_up      = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc};
    w_dn      = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
    w_diff    = w_up - w_dn;
    underflow = (w_dn > w_up);
    if (underflow) begin
      w_next = CNT_ZERO;
    end else if (w_diff > {1'b0, CNT_MAX}) begin
      w_next = CNT_MAX;
    end else begin
      w_next = w_diff[CNT_W-1:0];
    end
  end

  // Counter register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-first bypass and a per-register
// pending-writer scoreboard that raises stall on read-after-write hazards.
module regfile_sb
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [N-1:0]     r_regs [NREG];
  logic             r_sb_err;

  reg_idx_t         w_wr_idx;
  logic             w_wr_legal;
  logic             w_wr_illegal;
  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec_wb;
  logic [NREG-1:0]  w_dec_kill;
  logic [NREG-1:0]  w_underflow;
  logic             w_ready1;
  logic             w_ready2;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_wb_on_iss;
  logic             w_kill_on_iss;
  logic             w_ovf;
  logic             w_stall;

  assign w_wr_idx     = bus.regDest[REG_IDX_W-1:0];
  assign w_wr_legal   = bus.wr_en & ~bus.regDest[DEST_W-1] & (w_wr_idx != '0);
  assign w_wr_illegal = bus.wr_en & bus.regDest[DEST_W-1];

  // Register storage; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_legal) begin
      r_regs[w_wr_idx] <= bus.wr_data;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle legal write is bypassed.
  always_comb begin
    bus.rs1_data = r_regs[bus.rs1_addr];
    if (bus.rs1_addr == '0) begin
      bus.rs1_data = '0;
    end else if (w_wr_legal && (w_wr_idx == bus.rs1_addr)) begin
      bus.rs1_data = bus.wr_data;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    bus.rs2_data = r_regs[bus.rs2_addr];
    if (bus.rs2_addr == '0) begin
      bus.rs2_data = '0;
    end else if (w_wr_legal && (w_wr_idx == bus.rs2_addr)) begin
      bus.rs2_data = bus.wr_data;
    end
  end

  // Per-register decrement sources; x0's counter never moves.
  always_comb begin
    w_dec_wb   = '0;
    w_dec_kill = '0;
    for (int i = 1; i < NREG; i++) begin
      w_dec_wb[i]   = w_wr_legal & (w_wr_idx == reg_idx_t'(i));
      w_dec_kill[i] = bus.kill_valid & (bus.kill_rd == reg_idx_t'(i));
    end
  end

  // Per-register increment: only an issue that is not stalled counts.
  always_comb begin
    w_inc = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc[i] = bus.iss_valid & ~w_stall & (bus.iss_rd == reg_idx_t'(i));
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc[gi]),
      .dec_a     (w_dec_wb[gi]),
      .dec_b     (w_dec_kill[gi]),
      .cnt       (w_cnt[gi]),
      .underflow (w_underflow[gi])
    );
  end

  // Hazard and overflow detection; purely combinational from state and inputs.
  always_comb begin
    w_ready1 = (w_cnt[bus.rs1_addr] == CNT_ZERO) ||
               ((w_cnt[bus.rs1_addr] == CNT_ONE) && w_wr_legal &&
                (w_wr_idx == bus.rs1_addr));
    w_ready2 = (w_cnt[bus.rs2_addr] == CNT_ZERO) ||
               ((w_cnt[bus.rs2_addr] == CNT_ONE) && w_wr_legal &&
                (w_wr_idx == bus.rs2_addr));
    w_haz1   = bus.rs1_used && (bus.rs1_addr != '0) && !w_ready1;
    w_haz2   = bus.rs2_used && (bus.rs2_addr != '0) && !w_ready2;
    // A retirement or squash of the same register this cycle frees a slot.
    w_wb_on_iss   = w_wr_legal && (w_wr_idx == bus.iss_rd);
    w_kill_on_iss = bus.kill_valid && (bus.kill_rd == bus.iss_rd);
    w_ovf    = bus.iss_valid && (bus.iss_rd != '0) &&
               (w_cnt[bus.iss_rd] == CNT_MAX) && !(w_wb_on_iss || w_kill_on_iss);
    w_stall  = w_haz1 || w_haz2 || w_ovf;
  end

  // Sticky error: illegal destination or any counter underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (w_wr_illegal || (|w_underflow)) begin
      r_sb_err <= 1'b1;
    end
  end

  // Expose counters for observation.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      bus.dbg_cnt[i] = w_cnt[i];
    end
  end

  assign bus.stall  = w_stall;
  assign bus.sb_err = r_sb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reads, bypass, scoreboard hazards,
// overflow guard, kill handling and the sticky error flag.
module tb_regfile_sb;
  import rv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.regDest    = '0;
    bus.wr_data    = '0;
    bus.rs1_addr   = '0;
    bus.rs2_addr   = '0;
    bus.rs1_used   = 1'b0;
    bus.rs2_used   = 1'b0;
    bus.iss_valid  = 1'b0;
    bus.iss_rd     = '0;
    bus.kill_valid = 1'b0;
    bus.kill_rd    = '0;
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks at +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wb(input logic [5:0] dest, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.regDest = dest;
    bus.wr_data = data;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
  endtask

  task automatic kill(input logic [4:0] rd);
    bus.kill_valid = 1'b1;
    bus.kill_rd    = rd;
  endtask

  function automatic logic [31:0] cnt_of(input int idx);
    return 32'(bus.dbg_cnt[idx]);
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle();
    tick();
    do_reset();

    // Reset state.
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    bus.rs1_used = 1'b1;
    bus.rs2_used = 1'b1;
    settle();
    chk("rst_x5", bus.rs1_data, 32'h0);
    chk("rst_x0", bus.rs2_data, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_err", 32'(bus.sb_err), 32'd0);

    // Issue x7, then write it with a same-cycle read (bypass).
    idle();
    issue(5'd7);
    tick();
    idle();
    wb(6'd7, 32'hDEADBEEF);
    bus.rs1_addr = 5'd7;
    bus.rs1_used = 1'b1;
    settle();
    chk("byp_x7", bus.rs1_data, 32'hDEADBEEF);
    chk("byp_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.wr_en = 1'b0;
    settle();
    chk("stor_x7", bus.rs1_data, 32'hDEADBEEF);
    chk("cnt7_zero", cnt_of(7), 32'd0);

    // RAW hazard on x3.
    idle();
    issue(5'd3);
    settle();
    chk("iss3_nostall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    bus.rs2_addr = 5'd3;
    bus.rs2_used = 1'b0;
    settle();
    chk("haz3_unused", 32'(bus.stall), 32'd0);
    bus.rs2_used = 1'b1;
    settle();
    chk("haz3_stall", 32'(bus.stall), 32'd1);
    chk("cnt3_one", cnt_of(3), 32'd1);
    tick();
    wb(6'd3, 32'h12345678);
    settle();
    chk("wb3_unstall", 32'(bus.stall), 32'd0);
    chk("wb3_byp", bus.rs2_data, 32'h12345678);
    tick();
    bus.wr_en = 1'b0;
    settle();
    chk("cnt3_zero", cnt_of(3), 32'd0);
    chk("after3_stall", 32'(bus.stall), 32'd0);

    // Overflow guard on x4.
    idle();
    for (int k = 0; k < 3; k++) begin
      issue(5'd4);
      settle();
      chk("iss4_ok", 32'(bus.stall), 32'd0);
      tick();
    end
    chk("cnt4_three", cnt_of(4), 32'd3);
    issue(5'd4);
    settle();
    chk("ovf4_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("ovf4_held", cnt_of(4), 32'd3);
    kill(5'd4);
    settle();
    chk("ovf4_kill_ok", 32'(bus.stall), 32'd0);
    tick();
    idle();
    settle();
    chk("ovf4_kill_cnt", cnt_of(4), 32'd3);

    // Same-cycle issue and WB of x9.
    issue(5'd9);
    tick();
    idle();
    chk("cnt9_one", cnt_of(9), 32'd1);
    issue(5'd9);
    wb(6'd9, 32'h00000099);
    settle();
    chk("iw9_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    bus.rs1_addr = 5'd9;
    bus.rs1_used = 1'b1;
    settle();
    chk("iw9_cnt", cnt_of(9), 32'd1);
    chk("rd9_stall", 32'(bus.stall), 32'd1);
    kill(5'd9);
    tick();
    bus.kill_valid = 1'b0;
    settle();
    chk("kill9_cnt", cnt_of(9), 32'd0);
    chk("kill9_stall", 32'(bus.stall), 32'd0);
    chk("kill9_err", 32'(bus.sb_err), 32'd0);

    // Kill underflow on x6.
    idle();
    kill(5'd6);
    tick();
    idle();
    settle();
    chk("unf6_cnt", cnt_of(6), 32'd0);
    chk("unf6_err", 32'(bus.sb_err), 32'd1);

    // Reset clears error, storage and pending counts.
    do_reset();
    bus.rs1_addr = 5'd7;
    settle();
    chk("rst2_err", 32'(bus.sb_err), 32'd0);
    chk("rst2_x7", bus.rs1_data, 32'h0);
    chk("rst2_cnt4", cnt_of(4), 32'd0);

    // Illegal destination: x2 untouched, sticky error.
    idle();
    issue(5'd2);
    tick();
    idle();
    wb(6'd2, 32'h22222222);
    tick();
    idle();
    wb(6'b100010, 32'h0BAD0BAD);
    bus.rs1_addr = 5'd2;
    settle();
    chk("ill_nobyp", bus.rs1_data, 32'h22222222);
    tick();
    idle();
    bus.rs1_addr = 5'd2;
    settle();
    chk("ill_x2", bus.rs1_data, 32'h22222222);
    chk("ill_err", 32'(bus.sb_err), 32'd1);
    chk("ill_cnt2", cnt_of(2), 32'd0);
    tick();
    tick();
    chk("ill_sticky", 32'(bus.sb_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
